// File: rtl/shr_pkg.sv
// Shared types and defaults for the multi-cycle right shifter (shr_seq).
package shr_pkg;

    localparam int unsigned SHR_DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shr_state_t;

endpackage

// File: rtl/shr_stage.sv
// One combinational right-shift stage: shifts by dist_i when en_i, filling vacated MSBs
// with fill_i.
module shr_stage
    import shr_pkg::*;
#(
    parameter int unsigned WIDTH = SHR_DEF_WIDTH,
    localparam int unsigned DIST_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  data_i,
    input  logic              en_i,
    input  logic [DIST_W-1:0] dist_i,
    input  logic              fill_i,
    output logic [WIDTH-1:0]  data_o
);

    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        // Ones exactly in the bit positions vacated by the shift.
        fill_mask = ~({WIDTH{1'b1}} >> dist_i);
        data_o    = data_i;
        if (en_i) begin
            data_o = (data_i >> dist_i) | (fill_i ? fill_mask : '0);
        end
    end

endmodule

// File: rtl/shr_seq.sv
// Multi-cycle right shifter resolving one shamt bit per clock with a start/busy/done handshake.
// Define SHR_ARITH_EN to add the arith_i port and arithmetic (sra) fill.
module shr_seq
    import shr_pkg::*;
#(
    parameter int unsigned WIDTH = SHR_DEF_WIDTH,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   target_i,
`ifdef SHR_ARITH_EN
    input  logic               arith_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o
);

    localparam int unsigned CNT_W = $clog2(SHAMT_W);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SHAMT_W - 1);

    shr_state_t         state_q;
    logic [WIDTH-1:0]   result_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fill_q;
    logic               busy_q;
    logic               done_q;

    logic               start_fill;
    logic               stage_en;
    logic [SHAMT_W-1:0] stage_dist;
    logic [WIDTH-1:0]   stage_out;

`ifdef SHR_ARITH_EN
    // Sign bit is captured once at acceptance and reused for every stage.
    assign start_fill = arith_i & target_i[WIDTH-1];
`else
    assign start_fill = 1'b0;
`endif

    assign stage_en   = shamt_q[cnt_q];
    assign stage_dist = SHAMT_W'(1) << cnt_q;

    shr_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .data_i (result_q),
        .en_i   (stage_en),
        .dist_i (stage_dist),
        .fill_i (fill_q),
        .data_o (stage_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            shamt_q  <= '0;
            cnt_q    <= '0;
            fill_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q  <= SHIFT;
                        busy_q   <= 1'b1;
                        result_q <= target_i;
                        shamt_q  <= shamt_i;
                        cnt_q    <= '0;
                        fill_q   <= start_fill;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    result_q <= stage_out;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CntLast) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_shr_seq.sv
// Self-checking bench for shr_seq: countdown reference model plus directed literal cases
// and randomized traffic. Honours SHR_ARITH_EN.
module tb_shr_seq;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;
`ifdef SHR_ARITH_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          arith = 1'b0;
    logic [SW-1:0] shamt = '0;
    logic [W-1:0]  target = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    shr_seq #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .shamt_i  (shamt),
        .target_i (target),
`ifdef SHR_ARITH_EN
        .arith_i  (arith),
`endif
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    function automatic logic [W-1:0] ref_shr(input logic [W-1:0] t, input logic [SW-1:0] s,
                                             input logic a);
        if (a) return W'($signed(t) >>> s);
        return t >> s;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles remaining until the result is final.
    int           m_rem = 0;
    logic         m_done = 1'b0;
    logic         m_known = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_final = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem   = 0;
            m_done  = 1'b0;
            m_res   = '0;
            m_known = 1'b1;
        end else if (m_rem == 0 && start) begin
            m_rem   = SW;
            m_final = ref_shr(target, shamt, arith & ARITH);
            m_done  = 1'b0;
            m_known = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done  = 1'b1;
                m_res   = m_final;
                m_known = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    always @(negedge clk) begin
        check("model_busy", W'(busy), W'(m_rem > 0));
        check("model_done", W'(done), W'(m_done));
        if (m_known) check("model_result", result, m_res);
    end

    // Call at a negedge; returns at the negedge right after the accepting edge.
    task automatic launch(input logic [W-1:0] t, input logic [SW-1:0] s, input logic a);
        target = t;
        shamt  = s;
        arith  = a;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        target = $urandom;
        shamt  = SW'($urandom);
    endtask

    // n0 = negedges already elapsed since the accepting edge.
    task automatic wait_done(input int n0, output int n, output int bc);
        n  = n0;
        bc = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    int n;
    int bc;
    int d0;

    initial begin
        @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_busy", W'(busy), 32'h0);
        check("reset_done", W'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Logical full shift
        d0 = done_cnt;
        launch(32'h8000_0000, 5'd31, 1'b0);
        wait_done(1, n, bc);
        check("full_latency", W'(n - 1), W'(SW));
        check("full_busy_cycles", W'(bc), W'(SW));
        check("full_result", result, 32'h0000_0001);
        repeat (3) @(negedge clk);
        check("full_done_pulses", W'(done_cnt - d0), 32'd1);

        // Zero shift
        d0 = done_cnt;
        launch(32'hDEAD_BEEF, 5'd0, 1'b0);
        wait_done(1, n, bc);
        check("zero_latency", W'(n - 1), W'(SW));
        check("zero_result", result, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        check("zero_done_pulses", W'(done_cnt - d0), 32'd1);

        // Arithmetic vs logical fill
        launch(32'h8000_0000, 5'd4, 1'b1);
        wait_done(1, n, bc);
`ifdef SHR_ARITH_EN
        check("sra_result", result, 32'hF800_0000);
`else
        check("sra_result", result, 32'h0800_0000);
`endif
        @(negedge clk);
        launch(32'h8000_0000, 5'd4, 1'b0);
        wait_done(1, n, bc);
        check("srl_result", result, 32'h0800_0000);
        @(negedge clk);

        // Start while busy is ignored
        d0 = done_cnt;
        launch(32'h0000_FF00, 5'd8, 1'b0);
        target = 32'hFFFF_FFFF;
        shamt  = 5'd1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(2, n, bc);
        check("busy_ign_latency", W'(n - 1), W'(SW));
        check("busy_ign_result", result, 32'h0000_00FF);
        repeat (8) @(negedge clk);
        check("busy_ign_done_pulses", W'(done_cnt - d0), 32'd1);

        // Back-to-back start in the DONE cycle
        launch(32'h1234_5678, 5'd12, 1'b0);
        wait_done(1, n, bc);
        check("b2b_first_result", result, 32'h0001_2345);
        launch(32'h0000_0010, 5'd4, 1'b0);
        wait_done(1, n, bc);
        check("b2b_latency", W'(n - 1), W'(SW));
        check("b2b_second_result", result, 32'h0000_0001);
        @(negedge clk);

        // Reset in the third SHIFT cycle aborts
        launch(32'hA5A5_A5A5, 5'd7, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", W'(busy), 32'h0);
        check("abort_done", W'(done), 32'h0);
        check("abort_result", result, 32'h0);
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        check("abort_no_done", W'(done_cnt - d0), 32'd0);
        launch(32'h0F00_0000, 5'd24, 1'b0);
        wait_done(1, n, bc);
        check("after_abort_result", result, 32'h0000_000F);
        @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 2) == 0);
            target = $urandom;
            shamt  = SW'($urandom);
            arith  = 1'($urandom);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
